mat_bank_buffer: RTL and testbench

// Multi-bank matrix store between the host matrix source and the LU/triangular-inverse engine.

---
 rtl/mat_bank_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_mat_bank_buffer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_bank_buffer.sv
// Multi-bank complex matrix store: host loads rows, the engine reads/writes its owned bank,
// and finished banks stream out row-major or column-major.
module mat_bank_buffer #(
  parameter int SIZE      = 4,
  parameter int WIDTH     = 64,
  parameter int NUM_BANKS = 2,
  parameter int RD_LAT    = 1,
  localparam int ROW_W    = SIZE * 2 * WIDTH,
  localparam int AW       = $clog2(SIZE)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [ROW_W-1:0] load_row_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  output logic             eng_bank_vld_o,
  input  logic [AW-1:0]    eng_rd_addr_i,
  input  logic             eng_rd_req_i,
  output logic [ROW_W-1:0] eng_rd_row_o,
  output logic [AW-1:0]    eng_rd_addr_o,
  output logic             eng_rd_vld_o,
  input  logic [ROW_W-1:0] eng_wr_row_i,
  input  logic [AW-1:0]    eng_wr_addr_i,
  input  logic             eng_wr_valid_i,
  output logic             eng_wr_ready_o,
  input  logic             eng_done_i,
  input  logic             unload_mode_i,
  output logic [ROW_W-1:0] unload_data_o,
  output logic [AW-1:0]    unload_idx_o,
  output logic             unload_last_o,
  output logic             unload_valid_o,
  input  logic             unload_ready_i
);

  // state      | meaning
  // ST_EMPTY   | bank free, waiting for the first load beat
  // ST_LOADING | some rows loaded, more to come
  // ST_FULL    | all rows loaded, waiting for the engine pointer
  // ST_ENGINE  | owned by the engine (read / write-back)
  // ST_UNLOAD  | engine done, rows/columns streaming out
  typedef enum logic [2:0] {ST_EMPTY, ST_LOADING, ST_FULL, ST_ENGINE, ST_UNLOAD} bank_st_t;

  localparam int EW = 2 * WIDTH;
  localparam int PW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [ROW_W-1:0] mem [NUM_BANKS][SIZE];

  bank_st_t         bank_st_q [NUM_BANKS];
  bank_st_t         bank_st_d [NUM_BANKS];
  logic [PW-1:0]    ld_ptr_q, ld_ptr_d, eng_ptr_q, eng_ptr_d, ul_ptr_q, ul_ptr_d;
  logic [AW-1:0]    ld_row_q, ld_row_d, ul_idx_q, ul_idx_d;
  logic             ul_act_q, ul_act_d, ul_mode_q, ul_mode_d;
  logic             rd_vld_q  [RD_LAT];
  logic             rd_vld_d  [RD_LAT];
  logic [AW-1:0]    rd_addr_q [RD_LAT];
  logic [AW-1:0]    rd_addr_d [RD_LAT];
  logic [ROW_W-1:0] rd_row_q  [RD_LAT];
  logic [ROW_W-1:0] rd_row_d  [RD_LAT];

  logic load_acc, rd_acc, wr_acc, done_acc, ul_acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(NUM_BANKS - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign load_ready_o   = bank_st_q[ld_ptr_q] inside {ST_EMPTY, ST_LOADING};
  assign eng_bank_vld_o = (bank_st_q[eng_ptr_q] == ST_ENGINE);
  assign eng_wr_ready_o = eng_bank_vld_o;

  assign load_acc = load_valid_i & load_ready_o;
  assign rd_acc   = eng_rd_req_i & eng_bank_vld_o;
  assign wr_acc   = eng_wr_valid_i & eng_bank_vld_o;
  assign done_acc = eng_done_i & eng_bank_vld_o;
  assign ul_acc   = ul_act_q & unload_ready_i;

  always_comb begin
    bank_st_d = bank_st_q;
    ld_ptr_d  = ld_ptr_q;
    eng_ptr_d = eng_ptr_q;
    ul_ptr_d  = ul_ptr_q;
    ld_row_d  = ld_row_q;
    ul_idx_d  = ul_idx_q;
    ul_act_d  = ul_act_q;
    ul_mode_d = ul_mode_q;

    if (load_acc) begin
      if (ld_row_q == AW'(SIZE - 1)) begin
        bank_st_d[ld_ptr_q] = ST_FULL;
        ld_row_d            = '0;
        ld_ptr_d            = ptr_inc(ld_ptr_q);
      end else begin
        bank_st_d[ld_ptr_q] = ST_LOADING;
        ld_row_d            = ld_row_q + 1'b1;
      end
    end

    if (bank_st_q[eng_ptr_q] == ST_FULL) bank_st_d[eng_ptr_q] = ST_ENGINE;
    if (done_acc) begin
      bank_st_d[eng_ptr_q] = ST_UNLOAD;
      eng_ptr_d            = ptr_inc(eng_ptr_q);
    end

    // The unload mode is captured once per bank, when its first beat is presented.
    if (!ul_act_q && bank_st_q[ul_ptr_q] == ST_UNLOAD) begin
      ul_act_d  = 1'b1;
      ul_mode_d = unload_mode_i;
    end
    if (ul_acc) begin
      if (ul_idx_q == AW'(SIZE - 1)) begin
        bank_st_d[ul_ptr_q] = ST_EMPTY;
        ul_ptr_d            = ptr_inc(ul_ptr_q);
        ul_idx_d            = '0;
        ul_act_d            = 1'b0;
      end else begin
        ul_idx_d = ul_idx_q + 1'b1;
      end
    end

    // Read data is captured at request time, so same-cycle writes are not visible.
    rd_vld_d[0]  = rd_acc;
    rd_addr_d[0] = rd_acc ? eng_rd_addr_i : '0;
    rd_row_d[0]  = rd_acc ? mem[eng_ptr_q][eng_rd_addr_i] : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i]  = rd_vld_q[i-1];
      rd_addr_d[i] = rd_addr_q[i-1];
      rd_row_d[i]  = rd_row_q[i-1];
    end

    if (flush_i) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_st_d[b] = ST_EMPTY;
      ld_ptr_d  = '0;
      eng_ptr_d = '0;
      ul_ptr_d  = '0;
      ld_row_d  = '0;
      ul_idx_d  = '0;
      ul_act_d  = 1'b0;
      ul_mode_d = 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        rd_vld_d[i]  = 1'b0;
        rd_addr_d[i] = '0;
        rd_row_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_st_q[b] <= ST_EMPTY;
      ld_ptr_q  <= '0;
      eng_ptr_q <= '0;
      ul_ptr_q  <= '0;
      ld_row_q  <= '0;
      ul_idx_q  <= '0;
      ul_act_q  <= 1'b0;
      ul_mode_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        rd_vld_q[i]  <= 1'b0;
        rd_addr_q[i] <= '0;
        rd_row_q[i]  <= '0;
      end
    end else begin
      bank_st_q <= bank_st_d;
      ld_ptr_q  <= ld_ptr_d;
      eng_ptr_q <= eng_ptr_d;
      ul_ptr_q  <= ul_ptr_d;
      ld_row_q  <= ld_row_d;
      ul_idx_q  <= ul_idx_d;
      ul_act_q  <= ul_act_d;
      ul_mode_q <= ul_mode_d;
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      rd_row_q  <= rd_row_d;
    end
  end

  // Load and engine writes always target different banks, so both may fire together.
  always_ff @(posedge clk_i) begin
    if (!flush_i && load_acc) mem[ld_ptr_q][ld_row_q] <= load_row_i;
    if (!flush_i && wr_acc)   mem[eng_ptr_q][eng_wr_addr_i] <= eng_wr_row_i;
  end

  always_comb begin
    unload_data_o = '0;
    if (ul_act_q) begin
      if (ul_mode_q) begin
        for (int j = 0; j < SIZE; j++)
          unload_data_o[j*EW +: EW] = mem[ul_ptr_q][j][int'(ul_idx_q)*EW +: EW];
      end else begin
        unload_data_o = mem[ul_ptr_q][ul_idx_q];
      end
    end
  end

  assign unload_valid_o = ul_act_q;
  assign unload_idx_o   = ul_idx_q;
  assign unload_last_o  = ul_act_q && (ul_idx_q == AW'(SIZE - 1));

  assign eng_rd_vld_o  = rd_vld_q[RD_LAT-1];
  assign eng_rd_addr_o = rd_addr_q[RD_LAT-1];
  assign eng_rd_row_o  = rd_row_q[RD_LAT-1];

endmodule

// File: tb/tb_mat_bank_buffer.sv
// Directed bench for mat_bank_buffer: a default instance (RD_LAT=1) and an RD_LAT=3
// instance share all inputs; the second is only checked on its read pipeline.
module tb_mat_bank_buffer;
  localparam int SIZE = 4, WIDTH = 64, NB = 2;
  localparam int EW = 2 * WIDTH, ROW_W = SIZE * EW, AW = 2;

  logic clk = 1'b0;
  logic rst, flush;
  logic [ROW_W-1:0] load_row, wr_row;
  logic load_valid, rd_req, wr_valid, done, mode, ready;
  logic [AW-1:0] rd_addr, wr_addr;

  logic load_ready, eng_vld, rd_vld, wr_ready, ul_last, ul_valid;
  logic [ROW_W-1:0] rd_row, ul_data;
  logic [AW-1:0] rd_addr_o, ul_idx;

  logic load_ready3, eng_vld3, rd_vld3, wr_ready3, ul_last3, ul_valid3;
  logic [ROW_W-1:0] rd_row3, ul_data3;
  logic [AW-1:0] rd_addr_o3, ul_idx3;

  always #5 clk = ~clk;

  mat_bank_buffer #(.SIZE(SIZE), .WIDTH(WIDTH), .NUM_BANKS(NB), .RD_LAT(1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .load_row_i(load_row), .load_valid_i(load_valid), .load_ready_o(load_ready),
    .eng_bank_vld_o(eng_vld), .eng_rd_addr_i(rd_addr), .eng_rd_req_i(rd_req),
    .eng_rd_row_o(rd_row), .eng_rd_addr_o(rd_addr_o), .eng_rd_vld_o(rd_vld),
    .eng_wr_row_i(wr_row), .eng_wr_addr_i(wr_addr), .eng_wr_valid_i(wr_valid),
    .eng_wr_ready_o(wr_ready), .eng_done_i(done), .unload_mode_i(mode),
    .unload_data_o(ul_data), .unload_idx_o(ul_idx), .unload_last_o(ul_last),
    .unload_valid_o(ul_valid), .unload_ready_i(ready));

  mat_bank_buffer #(.SIZE(SIZE), .WIDTH(WIDTH), .NUM_BANKS(NB), .RD_LAT(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .load_row_i(load_row), .load_valid_i(load_valid), .load_ready_o(load_ready3),
    .eng_bank_vld_o(eng_vld3), .eng_rd_addr_i(rd_addr), .eng_rd_req_i(rd_req),
    .eng_rd_row_o(rd_row3), .eng_rd_addr_o(rd_addr_o3), .eng_rd_vld_o(rd_vld3),
    .eng_wr_row_i(wr_row), .eng_wr_addr_i(wr_addr), .eng_wr_valid_i(wr_valid),
    .eng_wr_ready_o(wr_ready3), .eng_done_i(done), .unload_mode_i(mode),
    .unload_data_o(ul_data3), .unload_idx_o(ul_idx3), .unload_last_o(ul_last3),
    .unload_valid_o(ul_valid3), .unload_ready_i(ready));

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] mat [3][SIZE][SIZE];

  typedef struct {
    logic [AW-1:0]    addr;
    logic [ROW_W-1:0] exp;
  } rd_vec_t;
  rd_vec_t tab [8];

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chka(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] row(input int m, input int i);
    logic [ROW_W-1:0] r;
    for (int j = 0; j < SIZE; j++) r[j*EW +: EW] = mat[m][i][j];
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] col(input int m, input int k);
    logic [ROW_W-1:0] r;
    for (int j = 0; j < SIZE; j++) r[j*EW +: EW] = mat[m][j][k];
    return r;
  endfunction

  task automatic load_matrix(input int m);
    for (int i = 0; i < SIZE; i++) begin
      load_valid = 1'b1;
      load_row   = row(m, i);
      step();
    end
    load_valid = 1'b0;
  endtask

  logic [ROW_W-1:0] aa;
  logic [AW-1:0]    rd_addrs [8];
  int               pat [4];
  int               k;

  initial begin
    rst = 1'b1; flush = 1'b0; load_valid = 1'b0; load_row = '0;
    rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_row = '0;
    done = 1'b0; mode = 1'b0; ready = 1'b0;

    for (int m = 0; m < 3; m++)
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++) begin
          logic [WIDTH-1:0] v;
          v = WIDTH'(64 * m + 8 * i + j);
          mat[m][i][j] = {-v, v};
        end
    aa = {8{64'hAAAA_AAAA_AAAA_AAAA}};
    rd_addrs = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd3, 2'd0, 2'd1, 2'd2};
    for (int t = 0; t < 8; t++) begin
      tab[t].addr = rd_addrs[t];
      tab[t].exp  = (t >= 4 && rd_addrs[t] == 2'd1) ? aa : row(0, int'(rd_addrs[t]));
    end
    pat = '{1, 0, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    chkb("rst_load_ready", load_ready, 1'b1);
    chkb("rst_eng_vld", eng_vld, 1'b0);
    chkb("rst_rd_vld", rd_vld, 1'b0);
    chkb("rst_ul_valid", ul_valid, 1'b0);
    chka("rst_ul_idx", ul_idx, '0);
    chkw("rst_rd_row", rd_row, '0);
    chkw("rst_ul_data", ul_data, '0);
    chkb("rst_rd_vld3", rd_vld3, 1'b0);
    rst = 1'b0;

    done = 1'b1; step(); done = 1'b0; step();
    chkb("ign_done_eng_vld", eng_vld, 1'b0);
    chkb("ign_done_ul_valid", ul_valid, 1'b0);

    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_row = row(2, i); step();
    end
    load_valid = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    chkb("flush_load_ready", load_ready, 1'b1);
    chkb("flush_eng_vld", eng_vld, 1'b0);

    load_matrix(0);
    chkb("a_full_eng_vld", eng_vld, 1'b0);
    step();
    chkb("a_eng_vld_rise", eng_vld, 1'b1);
    chkb("a_wr_ready", wr_ready, 1'b1);
    chkb("a_load_ready", load_ready, 1'b1);

    for (int t = 0; t < 4; t++) begin
      rd_req = 1'b1; rd_addr = tab[t].addr;
      step();
      rd_req = 1'b0;
      chkb($sformatf("rd%0d_vld", t), rd_vld, 1'b1);
      chka($sformatf("rd%0d_addr", t), rd_addr_o, tab[t].addr);
      chkw($sformatf("rd%0d_row", t), rd_row, tab[t].exp);
    end
    step();
    chkb("rd_idle_vld", rd_vld, 1'b0);

    rd_req = 1'b1; rd_addr = 2'd1; wr_valid = 1'b1; wr_addr = 2'd1; wr_row = aa;
    step();
    rd_req = 1'b0; wr_valid = 1'b0;
    chkw("rw_same_old", rd_row, row(0, 1));
    for (int j = 0; j < SIZE; j++) mat[0][1][j] = aa[EW-1:0];
    rd_req = 1'b1; rd_addr = 2'd1;
    step();
    rd_req = 1'b0;
    chkw("rw_after_new", rd_row, aa);

    step(); step();
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        rd_req = 1'b1; rd_addr = tab[4+c].addr;
      end else begin
        rd_req = 1'b0;
      end
      step();
      if (c < 4) begin
        chka($sformatf("b2b_lat1_addr%0d", c), rd_addr_o, tab[4+c].addr);
        chkw($sformatf("b2b_lat1_row%0d", c), rd_row, tab[4+c].exp);
      end
      if (c >= 2 && c < 6) begin
        chkb($sformatf("lat3_vld%0d", c - 2), rd_vld3, 1'b1);
        chka($sformatf("lat3_addr%0d", c - 2), rd_addr_o3, tab[4+c-2].addr);
        chkw($sformatf("lat3_row%0d", c - 2), rd_row3, tab[4+c-2].exp);
      end
      if (c == 6) chkb("lat3_vld_end", rd_vld3, 1'b0);
    end
    rd_req = 1'b0;

    for (int i = 0; i < SIZE; i++) begin
      chkb($sformatf("b_load_ready%0d", i), load_ready, 1'b1);
      load_valid = 1'b1; load_row = row(1, i);
      step();
    end
    load_valid = 1'b0;
    chkb("b_full_load_ready", load_ready, 1'b0);
    load_valid = 1'b1; load_row = row(2, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chkb($sformatf("c_blocked%0d", c), load_ready, 1'b0);
    end
    load_valid = 1'b0;

    mode = 1'b1; done = 1'b1; step(); done = 1'b0;
    chkb("a_done_eng_vld_fall", eng_vld, 1'b0);
    k = 0;
    for (int c = 0; c < 40 && k < SIZE; c++) begin
      ready = (pat[c % 4] != 0);
      if (ul_valid) begin
        chkw($sformatf("col_data%0d_c%0d", k, c), ul_data, col(0, k));
        chka($sformatf("col_idx%0d_c%0d", k, c), ul_idx, AW'(k));
        chkb($sformatf("col_last%0d_c%0d", k, c), ul_last, k == SIZE - 1);
        chkb($sformatf("col_load_ready%0d_c%0d", k, c), load_ready, 1'b0);
        if (ready) k++;
      end
      step();
    end
    ready = 1'b0;
    checks++;
    if (k != SIZE) begin
      errors++;
      $display("FAIL col_unload_beats: got %0d expected %0d", k, SIZE);
    end
    chkb("col_done_ul_valid", ul_valid, 1'b0);
    chkb("col_done_load_ready", load_ready, 1'b1);
    chkb("b_eng_vld", eng_vld, 1'b1);
    rd_req = 1'b1; rd_addr = 2'd3;
    step();
    rd_req = 1'b0;
    chkw("b_rd_row3", rd_row, row(1, 3));

    load_matrix(2);
    mode = 1'b0; done = 1'b1; step(); done = 1'b0;
    chkb("b_done_eng_vld_fall", eng_vld, 1'b0);
    step();
    chkb("c_eng_vld", eng_vld, 1'b1);
    chkb("row_ul_valid0", ul_valid, 1'b1);
    chka("row_ul_idx0", ul_idx, 2'd0);
    chkw("row_ul_data0", ul_data, row(1, 0));
    rd_req = 1'b1; rd_addr = 2'd0; ready = 1'b1;
    step();
    rd_req = 1'b0;
    chkw("c_rd_row0", rd_row, row(2, 0));
    chka("row_ul_idx1", ul_idx, 2'd1);
    chkw("row_ul_data1", ul_data, row(1, 1));
    step();
    ready = 1'b0;
    chka("row_ul_idx2", ul_idx, 2'd2);
    chkb("row_ul_valid2", ul_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chkb("midrst_ul_valid", ul_valid, 1'b0);
    chkb("midrst_load_ready", load_ready, 1'b1);
    chkb("midrst_eng_vld", eng_vld, 1'b0);
    chka("midrst_ul_idx", ul_idx, 2'd0);
    chkb("midrst_rd_vld", rd_vld, 1'b0);
    step();
    rst = 1'b0;
    step();
    chkb("post_rst_load_ready", load_ready, 1'b1);
    chkb("post_rst_ul_valid", ul_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
